// File: rtl/post_adder_acc.sv
// post_adder_acc: post-adder / accumulator stage of a DSP48A1-style slice.
// X and Z operand muxes feed a 49-bit add/subtract. It also holds the
// optional carry-in (CYI), P and CARRYOUT registers.
//
// Ports:
//   clk        rising-edge clock
//   RST_n      asynchronous active-low reset of every register
//   RSTP       synchronous clear of P and CARRYOUT
//   RSTCARRYIN synchronous clear of CYI
//   CEP        clock enable of P and CARRYOUT
//   CECARRYIN  clock enable of CYI
//   OPMODE     [1:0] X select, [3:2] Z select, [4] subtract
//   CARRYIN    carry-in
//   M          multiplier product, zero-extended to WIDTH_P
//   DAB        D:A:B concatenation
//   C          C operand
//   PCIN       cascade input
//   P, PCOUT   result and its cascade copy
//   CARRYOUT, CARRYOUTF  carry/borrow out and its fabric copy
module post_adder_acc #(
  parameter int WIDTH_P     = 48,
  parameter int WIDTH_M     = 36,
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic               RSTP,
  input  logic               RSTCARRYIN,
  input  logic               CEP,
  input  logic               CECARRYIN,
  input  logic [4:0]         OPMODE,
  input  logic               CARRYIN,
  input  logic [WIDTH_M-1:0] M,
  input  logic [WIDTH_P-1:0] DAB,
  input  logic [WIDTH_P-1:0] C,
  input  logic [WIDTH_P-1:0] PCIN,
  output logic [WIDTH_P-1:0] P,
  output logic [WIDTH_P-1:0] PCOUT,
  output logic               CARRYOUT,
  output logic               CARRYOUTF
);

  logic               cin;
  logic [WIDTH_P-1:0] p_fb;
  logic [WIDTH_P-1:0] x_op;
  logic [WIDTH_P-1:0] z_op;
  logic [WIDTH_P:0]   r;

  // Carry-in stage: registered form lags CARRYIN by one cycle to line up
  // with the upstream M register.
  if (CARRYINREG != 0) begin : g_cyi_reg
    logic cyi_q;
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)          cyi_q <= 1'b0;
      else if (RSTCARRYIN) cyi_q <= 1'b0;
      else if (CECARRYIN)  cyi_q <= CARRYIN;
    end
    assign cin = cyi_q;
  end else begin : g_cyi_comb
    assign cin = RSTCARRYIN ? 1'b0 : CARRYIN;
  end

  always_comb begin
    x_op = '0;
    case (OPMODE[1:0])
      2'd0: x_op = '0;
      2'd1: x_op = {{(WIDTH_P-WIDTH_M){1'b0}}, M};
      2'd2: x_op = p_fb;
      2'd3: x_op = DAB;
      default: x_op = '0;
    endcase
  end

  always_comb begin
    z_op = '0;
    case (OPMODE[3:2])
      2'd0: z_op = '0;
      2'd1: z_op = PCIN;
      2'd2: z_op = p_fb;
      2'd3: z_op = C;
      default: z_op = '0;
    endcase
  end

  // 49-bit arithmetic; when subtracting, the top bit is the borrow.
  always_comb begin
    if (OPMODE[4])
      r = {1'b0, z_op} - ({1'b0, x_op} + {{WIDTH_P{1'b0}}, cin});
    else
      r = {1'b0, z_op} + {1'b0, x_op} + {{WIDTH_P{1'b0}}, cin};
  end

  if (PREG != 0) begin : g_preg
    logic [WIDTH_P-1:0] p_q;
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)    p_q <= '0;
      else if (RSTP) p_q <= '0;
      else if (CEP)  p_q <= r[WIDTH_P-1:0];
    end
    assign P    = p_q;
    assign p_fb = p_q;
  end else begin : g_pcomb
    assign P    = RSTP ? '0 : r[WIDTH_P-1:0];
    // Feedback reads zero to avoid a combinational loop through the adder.
    assign p_fb = '0;
  end

  if (CARRYOUTREG != 0) begin : g_coreg
    logic co_q;
    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)    co_q <= 1'b0;
      else if (RSTP) co_q <= 1'b0;
      else if (CEP)  co_q <= r[WIDTH_P];
    end
    assign CARRYOUT = co_q;
  end else begin : g_cocomb
    assign CARRYOUT = RSTP ? 1'b0 : r[WIDTH_P];
  end

  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_post_adder_acc.sv
module tb_post_adder_acc;

  logic        clk = 1'b0;
  logic        RST_n;
  logic        RSTP;
  logic        RSTCARRYIN;
  logic        CEP;
  logic        CECARRYIN;
  logic [4:0]  OPMODE;
  logic        CARRYIN;
  logic [35:0] M;
  logic [47:0] DAB;
  logic [47:0] C;
  logic [47:0] PCIN;

  logic [47:0] P, PCOUT, Pc, PCOUTc;
  logic        CARRYOUT, CARRYOUTF, COc, COFc;

  post_adder_acc dut (
    .clk(clk), .RST_n(RST_n), .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN),
    .CEP(CEP), .CECARRYIN(CECARRYIN), .OPMODE(OPMODE), .CARRYIN(CARRYIN),
    .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  post_adder_acc #(.CARRYINREG(0), .PREG(0), .CARRYOUTREG(0)) dut_c (
    .clk(clk), .RST_n(RST_n), .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN),
    .CEP(CEP), .CECARRYIN(CECARRYIN), .OPMODE(OPMODE), .CARRYIN(CARRYIN),
    .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .P(Pc), .PCOUT(PCOUTc), .CARRYOUT(COc), .CARRYOUTF(COFc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state of the fully registered instance.
  logic [47:0] m_p;
  logic        m_co;
  logic        m_cyi;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec arithmetic in 64-bit integers, truncated to 49 bits (mod 2^49).
  function automatic logic [48:0] alu(input logic [4:0] op, input logic [47:0] pfb,
                                      input logic ci);
    longint unsigned x, z, r;
    case (op[1:0])
      2'd0: x = 0;
      2'd1: x = {28'd0, M};
      2'd2: x = {16'd0, pfb};
      default: x = {16'd0, DAB};
    endcase
    case (op[3:2])
      2'd0: z = 0;
      2'd1: z = {16'd0, PCIN};
      2'd2: z = {16'd0, pfb};
      default: z = {16'd0, C};
    endcase
    if (op[4]) r = z - x - 64'(ci);
    else       r = z + x + 64'(ci);
    return r[48:0];
  endfunction

  task automatic check_outputs();
    logic [48:0] rc;
    chk("P", {16'd0, P}, {16'd0, m_p});
    chk("PCOUT", {16'd0, PCOUT}, {16'd0, m_p});
    chk("CARRYOUT", {63'd0, CARRYOUT}, {63'd0, m_co});
    chk("CARRYOUTF", {63'd0, CARRYOUTF}, {63'd0, m_co});
    rc = RSTP ? 49'd0 : alu(OPMODE, 48'd0, RSTCARRYIN ? 1'b0 : CARRYIN);
    chk("P_comb", {16'd0, Pc}, {16'd0, rc[47:0]});
    chk("PCOUT_comb", {16'd0, PCOUTc}, {16'd0, rc[47:0]});
    chk("CO_comb", {63'd0, COc}, {63'd0, rc[48]});
    chk("COF_comb", {63'd0, COFc}, {63'd0, rc[48]});
  endtask

  // One rising edge: advance the reference with the inputs present at the
  // edge, then compare shortly after.
  task automatic step();
    logic [48:0] r;
    @(posedge clk);
    r = alu(OPMODE, m_p, m_cyi);
    if (RSTP) begin
      m_p = '0; m_co = 1'b0;
    end else if (CEP) begin
      m_p = r[47:0]; m_co = r[48];
    end
    if (RSTCARRYIN)     m_cyi = 1'b0;
    else if (CECARRYIN) m_cyi = CARRYIN;
    #1;
    check_outputs();
  endtask

  task automatic async_reset_pulse();
    #2 RST_n = 1'b0;
    m_p = '0; m_co = 1'b0; m_cyi = 1'b0;
    #1;
    chk("rst_P", {16'd0, P}, 64'd0);
    chk("rst_CARRYOUT", {63'd0, CARRYOUT}, 64'd0);
    #2 RST_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        cep;
    logic        rstp;
    logic [47:0] ep;
    logic        eco;
  } vec_t;

  vec_t vec[13];

  initial begin
    vec[0]  = '{5'b01101, 36'h3, 48'h0,    48'h10, 48'h0,   1'b1, 1'b0, 48'h13, 1'b0};
    vec[1]  = '{5'b01001, 36'h5, 48'h0,    48'h0,  48'h0,   1'b1, 1'b0, 48'h18, 1'b0};
    vec[2]  = '{5'b01001, 36'h5, 48'h0,    48'h0,  48'h0,   1'b1, 1'b1, 48'h0,  1'b0};
    vec[3]  = '{5'b01001, 36'h5, 48'h0,    48'h0,  48'h0,   1'b1, 1'b0, 48'd5,  1'b0};
    vec[4]  = '{5'b01001, 36'h5, 48'h0,    48'h0,  48'h0,   1'b1, 1'b0, 48'd10, 1'b0};
    vec[5]  = '{5'b01001, 36'h5, 48'h0,    48'h0,  48'h0,   1'b0, 1'b0, 48'd10, 1'b0};
    vec[6]  = '{5'b01001, 36'h5, 48'h0,    48'h0,  48'h0,   1'b1, 1'b0, 48'd15, 1'b0};
    vec[7]  = '{5'b01001, 36'h5, 48'h0,    48'h0,  48'h0,   1'b1, 1'b0, 48'd20, 1'b0};
    vec[8]  = '{5'b11111, 36'h0, 48'h8,    48'h5,  48'h0,   1'b1, 1'b0, 48'hFFFF_FFFF_FFFD, 1'b1};
    vec[9]  = '{5'b11111, 36'h0, 48'h5,    48'h8,  48'h0,   1'b1, 1'b0, 48'h3,  1'b0};
    vec[10] = '{5'b00110, 36'h0, 48'h0,    48'h0,  48'h100, 1'b1, 1'b0, 48'h103, 1'b0};
    vec[11] = '{5'b00111, 36'h0, 48'h1234, 48'h0,  48'h10,  1'b1, 1'b0, 48'h1244, 1'b0};
    vec[12] = '{5'b00000, 36'h0, 48'h0,    48'h0,  48'h0,   1'b1, 1'b0, 48'h0,  1'b0};

    RST_n = 1'b0; RSTP = 1'b0; RSTCARRYIN = 1'b0; CEP = 1'b1; CECARRYIN = 1'b1;
    OPMODE = '0; CARRYIN = 1'b0; M = '0; DAB = '0; C = '0; PCIN = '0;
    m_p = '0; m_co = 1'b0; m_cyi = 1'b0;

    // Reset state, with a clock edge occurring while reset is held.
    #12;
    check_outputs();
    @(negedge clk);
    RST_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      OPMODE = vec[i].op; M = vec[i].m; DAB = vec[i].dab; C = vec[i].c;
      PCIN = vec[i].pcin; CEP = vec[i].cep; RSTP = vec[i].rstp;
      step();
      chk($sformatf("tbl%0d_P", i), {16'd0, P}, {16'd0, vec[i].ep});
      chk($sformatf("tbl%0d_CO", i), {63'd0, CARRYOUT}, {63'd0, vec[i].eco});
    end
    CEP = 1'b1; RSTP = 1'b0;

    // Accumulate to 0x10, then asynchronous reset mid-cycle, then RSTP with CEP.
    OPMODE = 5'b01001; M = 36'h10;
    step();
    chk("acc_0x10", {16'd0, P}, 64'h10);
    async_reset_pulse();
    RSTP = 1'b1;
    step();
    chk("rstp_cep_P", {16'd0, P}, 64'd0);
    RSTP = 1'b0; M = 36'h7;
    step();
    chk("restart_P", {16'd0, P}, 64'h7);

    // Wrap and carry.
    OPMODE = 5'b01111; DAB = '0; C = 48'hFFFF_FFFF_FFFF;
    step();
    OPMODE = 5'b01001; M = 36'h1;
    step();
    chk("wrap_P", {16'd0, P}, 64'd0);
    chk("wrap_CO", {63'd0, CARRYOUT}, 64'd1);
    M = '0;
    step();
    chk("wrap_CO_next", {63'd0, CARRYOUT}, 64'd0);

    // Carry-in path: registered lags one edge; combinational is immediate.
    OPMODE = 5'b00000; CARRYIN = 1'b1;
    step();
    chk("cin_comb_P", {16'd0, Pc}, 64'd1);
    chk("cin_reg_first", {16'd0, P}, 64'd0);
    CARRYIN = 1'b0;
    step();
    chk("cin_reg_P", {16'd0, P}, 64'd1);
    step();
    chk("cin_reg_after", {16'd0, P}, 64'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      OPMODE     = 5'($urandom);
      CEP        = ($urandom_range(7) != 0);
      RSTP       = ($urandom_range(15) == 0);
      CECARRYIN  = ($urandom_range(3) != 0);
      RSTCARRYIN = ($urandom_range(15) == 0);
      CARRYIN    = 1'($urandom);
      if ($urandom_range(1) == 0) begin
        M = {4'($urandom), 32'($urandom)};
        DAB = {16'($urandom), 32'($urandom)};
        C = {16'($urandom), 32'($urandom)};
        PCIN = {16'($urandom), 32'($urandom)};
      end else begin
        M = 36'($urandom_range(3));
        DAB = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(3));
        C = 48'($urandom_range(3));
        PCIN = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(3));
      end
      step();
      if ($urandom_range(49) == 0) async_reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
